// File: rtl/arith_pkg.sv
// Shared arithmetic-block definitions: the serial subtractor's FSM state encoding.
package arith_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/fullsubtractor.sv
// One-bit full subtractor: difference and borrow-out for a - b - borrow_in.
module fullsubtractor (
   input  logic ain,
   input  logic bin,
   input  logic bin_in,
   output logic bout,
   output logic dout
);

   always_comb begin
      dout = ain ^ bin ^ bin_in;
      bout = (~ain & bin) | (~(ain ^ bin) & bin_in);
   end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes ain - bin LSB-first over WIDTH cycles,
// reporting the difference, the final borrow and signed overflow.
module serial_subtractor
   import arith_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] ain,
   input  logic [WIDTH-1:0] bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] dout,
   output logic             bout,
   output logic             ovf
);

   localparam int unsigned   CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] acc;
   logic             br;
   logic             d_bit;
   logic             br_nxt;

   fullsubtractor u_fs (
      .ain    (a_q[0]),
      .bin    (b_q[0]),
      .bin_in (br),
      .bout   (br_nxt),
      .dout   (d_bit)
   );

   // done is registered from the DONE state, so the pulse is seen the cycle
   // after DONE while the FSM is already back in IDLE (WIDTH+2 cycle period).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         a_q   <= '0;
         b_q   <= '0;
         acc   <= '0;
         br    <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         dout  <= '0;
         bout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_q   <= ain;
                  b_q   <= bin;
                  cnt   <= '0;
                  br    <= 1'b0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               a_q <= {1'b0, a_q[WIDTH-1:1]};
               b_q <= {1'b0, b_q[WIDTH-1:1]};
               acc <= {d_bit, acc[WIDTH-1:1]};
               br  <= br_nxt;
               cnt <= cnt + CW'(1);
               if (cnt == LAST) begin
                  // a_q[0]/b_q[0] hold the operand sign bits on the last step
                  dout  <= {d_bit, acc[WIDTH-1:1]};
                  bout  <= br_nxt;
                  ovf   <= (a_q[0] != b_q[0]) && (d_bit != a_q[0]);
                  busy  <= 1'b0;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): results and done timing.
module tb_serial_subtractor;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] ain;
   logic [W-1:0] bin;
   logic         busy;
   logic         done;
   logic [W-1:0] dout;
   logic         bout;
   logic         ovf;

   typedef struct {
      logic [W-1:0] d;
      logic         b;
      logic         v;
      int           acc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   nvec = 0;
   int   nerr = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .ain   (ain),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .dout  (dout),
      .bout  (bout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
      exp_t e;
      int   s;
      s     = int'($signed(a)) - int'($signed(b));
      e.d   = a - b;
      e.b   = (a < b);
      e.v   = (s > 127) || (s < -128);
      e.acc = acc;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            chk("spurious_done", 32'(done), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("dout", 32'(dout), 32'(e.d));
            chk("bout", 32'(bout), 32'(e.b));
            chk("ovf", 32'(ovf), 32'(e.v));
            chk("latency", 32'(cyc - e.acc), 32'(W + 1));
            chk("busy_at_done", 32'(busy), 32'd0);
         end
      end
   end

   task automatic drain();
      for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
      chk("drain", 32'(sb.size()), 32'd0);
      sb.delete();
      tick();
   endtask

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
      start = 1'b1;
      ain   = a;
      bin   = b;
      push(a, b, cyc + 1);
      tick();
      start = 1'b0;
      ain   = ~a;
      bin   = ~b;
      drain();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_dout"}, 32'(dout), 32'd0);
      chk({tag, "_bout"}, 32'(bout), 32'd0);
      chk({tag, "_ovf"}, 32'(ovf), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      start = 1'b1;
      ain   = 8'hAA;
      bin   = 8'h11;
      repeat (3) tick();
      chk_zero("reset");

      // first start accepted on the first edge with rst_n high
      rst_n = 1'b1;
      start = 1'b1;
      ain   = 8'h05;
      bin   = 8'h03;
      push(8'h05, 8'h03, cyc + 1);
      tick();
      start = 1'b0;
      ain   = 8'hFF;
      bin   = 8'h00;
      drain();

      do_op(8'h03, 8'h05);
      do_op(8'h00, 8'h00);
      do_op(8'h80, 8'h01);
      do_op(8'h7F, 8'hFF);

      // start during SHIFT is ignored
      start = 1'b1;
      ain   = 8'h20;
      bin   = 8'h01;
      push(8'h20, 8'h01, cyc + 1);
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("busy_shift", 32'(busy), 32'd1);
      start = 1'b1;
      ain   = 8'h10;
      bin   = 8'h01;
      tick();
      start = 1'b0;
      drain();
      repeat (12) tick();

      do_op(8'h7F, 8'hFF);

      // reset for one edge in the 4th SHIFT cycle aborts the operation
      start = 1'b1;
      ain   = 8'h20;
      bin   = 8'h01;
      tick();
      start = 1'b0;
      repeat (3) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk_zero("midreset");
      repeat (15) tick();
      chk_zero("after_abort");
      do_op(8'h40, 8'h0F);

      // start held high: three back-to-back operations, 10 cycles apart
      begin
         logic [W-1:0] ta [3];
         logic [W-1:0] tb [3];
         int           e0;
         ta[0] = 8'h05; tb[0] = 8'h03;
         ta[1] = 8'h80; tb[1] = 8'h01;
         ta[2] = 8'h03; tb[2] = 8'h05;
         start = 1'b1;
         ain   = ta[0];
         bin   = tb[0];
         e0    = cyc + 1;
         push(ta[0], tb[0], e0);
         tick();
         for (int k = 1; k < 3; k++) begin
            ain = ta[k];
            bin = tb[k];
            push(ta[k], tb[k], e0 + k * (W + 2));
            repeat (W + 2) tick();
         end
         start = 1'b0;
         ain   = 8'h00;
         bin   = 8'h00;
         for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
         chk("b2b_drain", 32'(sb.size()), 32'd0);
         sb.delete();
         tick();
      end

      for (int i = 0; i < 4; i++) do_op(W'($urandom), W'($urandom));

      repeat (12) tick();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  request a subtraction; sampled only in IDLE.
REQ-005 SHALL have port ain  input  WIDTH  minuend; sampled on the edge that accepts start.
REQ-006 SHALL have port bin  input  WIDTH  subtrahend; sampled on the edge that accepts start.
REQ-007 SHALL have port busy  output  1  high while in SHIFT.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking valid results.
REQ-009 SHALL have port dout  output  WIDTH  difference ain-bin, modulo 2^WIDTH.
REQ-010 SHALL have port bout  output  1  final borrow; high iff unsigned ain < bin.
REQ-011 SHALL have port ovf  output  1  signed (two's complement) overflow of ain-bin.

Function
REQ-012 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-013 SHALL move IDLE->SHIFT when start=1; on that edge it SHALL latch ain and bin, clear the bit counter and clear the borrow flop.
REQ-014 SHALL, in each SHIFT cycle, process one bit LSB-first: d = a_i ^ b_i ^ br and br' = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-015 SHALL shift d into the result register from the MSB end, so dout is bit-aligned after WIDTH shifts.
REQ-016 SHALL remain in SHIFT for exactly WIDTH cycles, then move to DONE; the counter SHALL NOT wrap before DONE is reached.
REQ-017 SHALL assert done only in DONE, for exactly one cycle, and then return to IDLE unconditionally.
REQ-018 Latency: with start sampled at edge E0, done SHALL be high during the cycle following edge E0+WIDTH+1.
REQ-019 SHALL update dout, bout and ovf at the SHIFT->DONE edge and hold them stable until the next accepted start; they are also valid while done=1.
REQ-020 SHALL compute ovf = a_msb ^ b_msb ^ ... equivalently (a_msb != b_msb) && (d_msb != a_msb), using the final bit.
REQ-021 SHALL ignore start while in SHIFT or DONE; no re-latch and no restart.
REQ-022 SHALL accept start held high continuously as back-to-back requests: one operation per WIDTH+2 cycles.
REQ-023 SHALL NOT be affected by changes on ain or bin after the accepting edge.

Reset
REQ-024 SHALL, on any edge with rst_n=0, enter IDLE and clear the counter, the borrow flop and the operand registers.
REQ-025 SHALL drive busy=0, done=0, dout=0, bout=0 and ovf=0 from the first edge with rst_n=0.
REQ-026 SHALL abort any in-progress operation on reset mid-SHIFT; no done pulse SHALL follow.
REQ-027 SHALL ignore start on an edge with rst_n=0; the first start is accepted on the first edge with rst_n=1.

Structure
REQ-028 SHALL place the FSM state enum (IDLE, SHIFT, DONE) in shared package arith_pkg.
REQ-029 SHALL instantiate one combinational sub-module fullsubtractor (inputs ain, bin, bin_in; outputs bout, dout) for the per-bit logic.
REQ-030 SHALL size the counter as $clog2(WIDTH+1) bits.

Verification (WIDTH=8)
REQ-031 SHALL test 0x05 - 0x03: done 10 cycles after start; dout=0x02, bout=0, ovf=0.
REQ-032 SHALL test 0x03 - 0x05: dout=0xFE, bout=1, ovf=0; and 0x00 - 0x00: dout=0x00, bout=0, ovf=0.
REQ-033 SHALL test 0x80 - 0x01: dout=0x7F, bout=0, ovf=1; and 0x7F - 0xFF: dout=0x80, bout=1, ovf=1.
REQ-034 SHALL test start pulsed with 0x10 - 0x01 during SHIFT of 0x20 - 0x01: it is ignored; result dout=0x1F with a single done pulse.
REQ-035 SHALL test rst_n=0 for one edge in the 4th SHIFT cycle: outputs go to 0, no done follows, and the next start computes correctly.
REQ-036 SHALL test start held high for 3 operations: 3 done pulses spaced exactly 10 cycles apart, with correct results.
